recorder_mem_ctrl: RTL and testbench

//  Sequencer and port scheduler for the audio recorder's single-port sample BRAM.
//  - Record mode: each audio_valid_in strobe writes one 8-bit sample.
//  - Playback mode: each strobe time-multiplexes 1+ECHO_TAPS reads (dry tap plus delayed echo taps)

---
 rtl/recorder_mem_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_recorder_mem_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/recorder_mem_ctrl.sv
// Record/playback sequencer and port scheduler for the recorder's single-port sample BRAM.
// Optional define PLAYBACK_LOOP_EN: playback wraps at the recorded length instead of stopping.
module recorder_mem_ctrl #(
   parameter int ADDR_W     = 16,
   parameter int ECHO_TAPS  = 2,
   parameter int ECHO_DELAY = 1500,
   parameter int BRAM_LAT   = 2
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              record_in,
   input  logic              audio_valid_in,
   input  logic [7:0]        audio_in,
   output logic [ADDR_W-1:0] mem_addr_out,
   output logic              mem_we_out,
   output logic [7:0]        mem_din_out,
   input  logic [7:0]        mem_dout_in,
   output logic [7:0]        single_out,
   output logic [7:0]        echo_out,
   output logic              out_valid_out,
   output logic              busy_out,
   output logic              full_out,
   output logic              overrun_out
);
   localparam int DEPTH = 2**ADDR_W;
   localparam int PW    = ADDR_W + 1;
   localparam int IW    = $clog2(ECHO_TAPS + 1);
   localparam int WW    = (BRAM_LAT < 2) ? 1 : $clog2(BRAM_LAT);
   localparam logic [IW-1:0] LAST_SLOT = IW'(ECHO_TAPS);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_WRITE = 3'd1;
   localparam logic [2:0] S_ISSUE = 3'd2;
   localparam logic [2:0] S_WAIT  = 3'd3;
   localparam logic [2:0] S_MIX   = 3'd4;

   logic [2:0]                  r_state;
   logic                        r_rec_q, r_rec_d;
   logic [PW-1:0]               r_wr_addr, r_play_addr, r_length;
   logic                        r_full, r_overrun;
   logic [IW-1:0]               r_slot;
   logic [WW-1:0]               r_wait;
   logic [BRAM_LAT:0]           r_vld_pipe;
   logic [BRAM_LAT:0][IW-1:0]   r_idx_pipe;
   logic [ECHO_TAPS:0][7:0]     r_tap;
   logic [ADDR_W-1:0]           r_addr;
   logic                        r_we, r_valid;
   logic [7:0]                  r_din, r_single, r_echo;

   logic                        w_rise, w_fall, w_play_ok;
   logic                        w_iss_go, w_iss_rd, w_big;
   logic [IW-1:0]               w_nslot;
   logic [PW-1:0]               w_off;
   logic [ADDR_W-1:0]           w_rd_addr;
   logic [ECHO_TAPS:0][7:0]     w_tap;
   logic signed [10:0]          w_acc;
   logic [7:0]                  w_echo;

   function automatic logic signed [10:0] sx(input logic [7:0] v);
      sx = {{3{v[7]}}, v};
   endfunction

   assign w_rise    = r_rec_q & ~r_rec_d;
   assign w_fall    = ~r_rec_q & r_rec_d;
   // play_addr==length covers both the empty buffer and the saturated end of playback
   assign w_play_ok = (r_play_addr != r_length);

   // Read slot that will be on the BRAM port during the next cycle
   always_comb begin
      w_iss_go = 1'b0;
      w_nslot  = '0;
      if (r_state == S_IDLE && audio_valid_in && !r_rec_q) begin
         w_iss_go = 1'b1;
      end else if (r_state == S_ISSUE && r_slot != LAST_SLOT) begin
         w_iss_go = 1'b1;
         w_nslot  = r_slot + 1'b1;
      end
   end

   always_comb begin
      w_off = '0;
      w_big = 1'b0;
      for (int k = 1; k <= ECHO_TAPS; k++) begin
         if (w_nslot == IW'(k)) begin
            w_off = PW'(k * ECHO_DELAY);
            w_big = (k * ECHO_DELAY > DEPTH);
         end
      end
   end

   assign w_iss_rd  = w_iss_go && w_play_ok && !w_big && (r_play_addr >= w_off);
   assign w_rd_addr = ADDR_W'(r_play_addr - w_off);

   // Last tap lands on the same edge that leaves WAIT, so merge it in before mixing
   always_comb begin
      w_tap = r_tap;
      if (r_vld_pipe[BRAM_LAT]) w_tap[r_idx_pipe[BRAM_LAT]] = mem_dout_in;
   end

   always_comb begin
      w_acc = sx(w_tap[0]);
      for (int k = 1; k <= ECHO_TAPS; k++) w_acc = w_acc + (sx(w_tap[k]) >>> k);
      if (w_acc > 11'sd127)       w_echo = 8'h7f;
      else if (w_acc < -11'sd128) w_echo = 8'h80;
      else                        w_echo = w_acc[7:0];
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_state     <= S_IDLE;
         r_rec_q     <= 1'b0;
         r_rec_d     <= 1'b0;
         r_wr_addr   <= '0;
         r_play_addr <= '0;
         r_length    <= '0;
         r_full      <= 1'b0;
         r_overrun   <= 1'b0;
         r_slot      <= '0;
         r_wait      <= '0;
         r_vld_pipe  <= '0;
         r_idx_pipe  <= '0;
         r_tap       <= '0;
         r_addr      <= '0;
         r_we        <= 1'b0;
         r_din       <= '0;
         r_valid     <= 1'b0;
         r_single    <= '0;
         r_echo      <= '0;
      end else begin
         r_rec_q    <= record_in;
         r_rec_d    <= r_rec_q;
         r_we       <= 1'b0;
         r_valid    <= 1'b0;
         r_vld_pipe <= {r_vld_pipe[BRAM_LAT-1:0], w_iss_rd};
         r_idx_pipe <= {r_idx_pipe[BRAM_LAT-1:0], w_nslot};
         if (w_iss_rd) r_addr <= w_rd_addr;
         if (r_vld_pipe[BRAM_LAT]) r_tap[r_idx_pipe[BRAM_LAT]] <= mem_dout_in;
         if (audio_valid_in && r_state != S_IDLE) r_overrun <= 1'b1;

         case (r_state)
            S_IDLE: begin
               if (audio_valid_in) begin
                  r_tap <= '0;
                  if (r_rec_q) begin
                     r_state <= S_WRITE;
                     if (!r_full) begin
                        r_we   <= 1'b1;
                        r_din  <= audio_in;
                        r_addr <= r_wr_addr[ADDR_W-1:0];
                     end
                  end else begin
                     r_state <= S_ISSUE;
                     r_slot  <= '0;
                  end
               end
            end
            S_WRITE: begin
               if (r_we) begin
                  r_wr_addr <= r_wr_addr + 1'b1;
                  if (r_wr_addr == PW'(DEPTH - 1)) r_full <= 1'b1;
               end
               r_state <= S_IDLE;
            end
            S_ISSUE: begin
               if (r_slot == LAST_SLOT) begin
                  r_state <= S_WAIT;
                  r_wait  <= '0;
               end else begin
                  r_slot <= r_slot + 1'b1;
               end
            end
            S_WAIT: begin
               if (r_wait == WW'(BRAM_LAT - 1)) begin
                  r_state  <= S_MIX;
                  r_valid  <= 1'b1;
                  r_single <= w_tap[0];
                  r_echo   <= w_echo;
               end else begin
                  r_wait <= r_wait + 1'b1;
               end
            end
            S_MIX: begin
               r_state <= S_IDLE;
`ifdef PLAYBACK_LOOP_EN
               if (w_play_ok)
                  r_play_addr <= (r_play_addr + PW'(1) == r_length) ? '0 : r_play_addr + PW'(1);
`else
               if (w_play_ok) r_play_addr <= r_play_addr + PW'(1);
`endif
            end
            default: r_state <= S_IDLE;
         endcase

         if (w_rise) begin
            r_wr_addr <= '0;
            r_full    <= 1'b0;
         end
         if (w_fall) begin
            r_length    <= r_wr_addr;
            r_play_addr <= '0;
         end
      end
   end

   assign mem_addr_out  = r_addr;
   assign mem_we_out    = r_we;
   assign mem_din_out   = r_din;
   assign single_out    = r_single;
   assign echo_out      = r_echo;
   assign out_valid_out = r_valid;
   assign busy_out      = (r_state != S_IDLE);
   assign full_out      = r_full;
   assign overrun_out   = r_overrun;
endmodule

// File: tb/tb_recorder_mem_ctrl.sv
// Randomized bench for recorder_mem_ctrl against a sample-level model of record/playback/echo.
module tb_recorder_mem_ctrl;
   localparam int AW      = 4;
   localparam int TAPS    = 2;
   localparam int DLY     = 4;
   localparam int LAT     = 2;
   localparam int DEPTH   = 16;
   localparam int OUT_CYC = 2 + TAPS + LAT;

   logic          clk = 1'b0, rst = 1'b1, rec = 1'b0, vld = 1'b0;
   logic [7:0]    ain = '0;
   logic [AW-1:0] maddr;
   logic          mwe, ov, busy, full, ovr;
   logic [7:0]    mdin, mdout, sgl, echo;

   recorder_mem_ctrl #(.ADDR_W(AW), .ECHO_TAPS(TAPS), .ECHO_DELAY(DLY), .BRAM_LAT(LAT)) u_dut (
      .clk_in(clk), .rst_in(rst), .record_in(rec), .audio_valid_in(vld), .audio_in(ain),
      .mem_addr_out(maddr), .mem_we_out(mwe), .mem_din_out(mdin), .mem_dout_in(mdout),
      .single_out(sgl), .echo_out(echo), .out_valid_out(ov), .busy_out(busy),
      .full_out(full), .overrun_out(ovr));

   always #5 clk = ~clk;

   // BRAM with LAT-cycle read latency
   logic [7:0] bram [DEPTH];
   logic [7:0] rdp  [LAT];
   always @(posedge clk) begin
      if (mwe) bram[maddr] <= mdin;
      rdp[0] <= bram[maddr];
      for (int i = 1; i < LAT; i++) rdp[i] <= rdp[i-1];
   end
   assign mdout = rdp[LAT-1];

   int m_mem [DEPTH];
   int m_wr, m_len, m_play;
   bit m_full, m_ovr, m_rec;
   int n_cmp = 0, n_bad = 0;

   task automatic chk(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ref_play(output int s, output int e);
      int t;
      bit ok;
      ok = (m_play != m_len);
      s  = ok ? m_mem[m_play] : 0;
      e  = s;
      for (int k = 1; k <= TAPS; k++) begin
         t = (ok && m_play >= k * DLY) ? m_mem[m_play - k * DLY] : 0;
         e += t >>> k;
      end
      if (e > 127)  e = 127;
      if (e < -128) e = -128;
`ifdef PLAYBACK_LOOP_EN
      if (ok) m_play = (m_play + 1 == m_len) ? 0 : m_play + 1;
`else
      if (ok) m_play = m_play + 1;
`endif
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      chk("rst_addr", maddr, 0);   chk("rst_we", mwe, 0);     chk("rst_din", mdin, 0);
      chk("rst_single", sgl, 0);   chk("rst_echo", echo, 0);  chk("rst_valid", ov, 0);
      chk("rst_busy", busy, 0);    chk("rst_full", full, 0);  chk("rst_ovr", ovr, 0);
      tick();
      rst = 1'b0;
      tick();
      m_wr = 0; m_len = 0; m_play = 0; m_full = 0; m_ovr = 0;
   endtask

   task automatic set_mode(input bit v);
      rec = v;
      repeat (3) tick();
      if (v && !m_rec) begin m_wr = 0; m_full = 0; end
      if (!v && m_rec) begin m_len = m_wr; m_play = 0; end
      m_rec = v;
   endtask

   task automatic rec_strobe(input int d);
      bit w;
      w   = !m_full;
      ain = d[7:0];
      vld = 1'b1;
      tick();
      vld = 1'b0;
      chk("wr_we", mwe, int'(w));
      if (w) begin
         chk("wr_addr", maddr, m_wr);
         chk("wr_data", mdin, d & 255);
         m_mem[m_wr] = int'($signed(ain));
         m_wr++;
         if (m_wr == DEPTH) m_full = 1;
      end
      tick();
      chk("wr_we_off", mwe, 0);
      chk("wr_full", full, int'(m_full));
      chk("wr_busy", busy, 0);
   endtask

   // Strobe in cycle 0, result expected in cycle OUT_CYC; an extra strobe may be injected at cycle 2
   task automatic play_strobe(input bit inject);
      int es, ee, early;
      ref_play(es, ee);
      ain = 8'($urandom);
      vld = 1'b1;
      tick();
      vld = 1'b0;
      chk("pl_busy", busy, 1);
      early = 0;
      for (int c = 1; c < OUT_CYC; c++) begin
         early |= int'(ov | mwe);
         if (inject && c == 2) vld = 1'b1;
         tick();
         vld = 1'b0;
      end
      if (inject) m_ovr = 1;
      chk("pl_early", early, 0);
      chk("pl_valid", ov, 1);
      chk("pl_we", mwe, 0);
      chk("pl_single", int'($signed(sgl)), es);
      chk("pl_echo", int'($signed(echo)), ee);
      tick();
      chk("pl_pulse", ov, 0);
      chk("pl_ovr", ovr, int'(m_ovr));
      repeat ($urandom_range(0, 2)) tick();
   endtask

   initial begin
      int n;
      m_rec = 0;
      for (int i = 0; i < DEPTH; i++) begin bram[i] = '0; m_mem[i] = 0; end
      tick();
      do_reset();

      play_strobe(0);                                  // empty buffer -> zeros

      set_mode(1);
      for (int i = 0; i < 10; i++) rec_strobe(i);
      set_mode(0);
      for (int i = 0; i < 12; i++) play_strobe(0);     // strobe 7: single 6, echo 7

      set_mode(1);
      for (int i = 0; i < 12; i++) rec_strobe(127);
      set_mode(0);
      for (int i = 0; i < 12; i++) play_strobe(0);
      set_mode(1);
      for (int i = 0; i < 12; i++) rec_strobe(128);    // -128
      set_mode(0);
      for (int i = 0; i < 12; i++) play_strobe(0);

      set_mode(1);
      for (int i = 0; i < 20; i++) rec_strobe($urandom_range(0, 255));
      set_mode(0);
      for (int i = 0; i < 18; i++) play_strobe(0);

      // reset while waiting on BRAM data
      ain = 8'h00; vld = 1'b1; tick(); vld = 1'b0;
      repeat (3) tick();
      do_reset();
      play_strobe(0);

      play_strobe(1);                                  // overrun
      for (int r = 0; r < 4; r++) begin
         set_mode(1);
         n = $urandom_range(1, 20);
         for (int i = 0; i < n; i++) begin
            rec_strobe($urandom_range(0, 255));
            repeat ($urandom_range(0, 2)) tick();
         end
         set_mode(0);
         for (int i = 0; i < n + 2; i++) play_strobe(0);
      end
      chk("ovr_sticky", ovr, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
